// File: rtl/engine_merge_data_setup_packet_encoder.sv
// Transmit-side merge-data setup encoder: pops index-range configurations and
// splits each range into NUM_LANES contiguous engine-setup packets.

package engine_merge_data_setup_packet_encoder_pkg;

    typedef enum logic [3:0] {
        STRUCT_INVALID      = 4'd0,
        STRUCT_KERNEL_SETUP = 4'd1,
        STRUCT_ENGINE_SETUP = 4'd2,
        STRUCT_ENGINE_DATA  = 4'd3
    } MemoryBufferType;

    typedef struct packed {
        logic [7:0] id_cu;
        logic [7:0] id_bundle;
        logic [7:0] id_lane;
        logic [7:0] id_engine;
    } MemoryRoute;

    typedef struct packed {
        logic [3:0]      cmd;
        MemoryBufferType buffer;
    } MemorySubclass;

    typedef struct packed {
        MemoryRoute    route;
        MemorySubclass subclass;
    } MemoryPacketMeta;

    typedef struct packed {
        logic [31:0] index_start;
        logic [31:0] index_end;
        logic [31:0] array_size;
    } CSRIndexParam;

    typedef struct packed {
        MemoryPacketMeta meta;
        CSRIndexParam    param;
    } CSRIndexConfigurationPayload;

    typedef struct packed {
        logic                        valid;
        CSRIndexConfigurationPayload payload;
    } CSRIndexConfiguration;

    typedef struct packed {
        logic [31:0] field_0;
        logic [31:0] field_1;
        logic [31:0] field_2;
        logic [31:0] field_3;
    } MemoryPacketData;

    // source identifies the encoder instance that produced the packet
    typedef struct packed {
        MemoryPacketMeta meta;
        MemoryPacketData data;
        MemoryRoute      source;
    } MemoryPacketPayload;

    typedef struct packed {
        logic               valid;
        MemoryPacketPayload payload;
    } MemoryPacket;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic full;
        logic empty;
        logic prog_full;
    } FIFOStateSignalsOutput;

endpackage

// Synchronous FIFO with a short reset-busy window after reset release;
// while busy it reports empty/full/prog_full so neither side moves data.
module EngineMergeDataSetupFifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int PROG_FULL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rdEn,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_progFull,
    output logic             o_rstBusy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_busyCnt;
    logic             w_wr;
    logic             w_rd;

    assign o_rstBusy  = (r_busyCnt != 2'd0);
    assign o_full     = o_rstBusy | (r_count == CNT_W'(DEPTH));
    assign o_empty    = o_rstBusy | (r_count == '0);
    assign o_progFull = o_rstBusy | (r_count >= CNT_W'(PROG_FULL));
    assign o_dout     = r_mem[r_rdPtr];
    assign w_wr       = i_wrEn & ~o_full;
    assign w_rd       = i_rdEn & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_busyCnt <= 2'd3;
        end else begin
            if (o_rstBusy) begin
                r_busyCnt <= r_busyCnt - 2'd1;
            end
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end
endmodule

module engine_merge_data_setup_packet_encoder
    import engine_merge_data_setup_packet_encoder_pkg::*;
#(
    parameter int ID_CU      = 0,
    parameter int ID_BUNDLE  = 0,
    parameter int ID_LANE    = 0,
    parameter int ID_ENGINE  = 0,
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  CSRIndexConfiguration  configure_in,
    input  FIFOStateSignalsInput  fifo_configure_in_signals_in,
    output FIFOStateSignalsOutput fifo_configure_in_signals_out,
    output MemoryPacket           request_engine_out,
    input  FIFOStateSignalsInput  fifo_request_engine_out_signals_in,
    output FIFOStateSignalsOutput fifo_request_engine_out_signals_out,
    output logic                  fifo_setup_signal,
    output logic                  encoder_busy_out
);
    localparam int LANE_SHIFT = $clog2(NUM_LANES);
    localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int IN_W       = $bits(CSRIndexConfigurationPayload);
    localparam int OUT_W      = $bits(MemoryPacketPayload);
    localparam int PROG_FULL  = FIFO_DEPTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
    } EncoderState;

    logic                        r_reset;
    logic                        r_inValid;
    CSRIndexConfigurationPayload r_inData;
    logic                        r_inRdEn;
    logic                        r_outRdEn;

    EncoderState                 r_state;
    MemoryPacketMeta             r_meta;
    logic [31:0]                 r_start;
    logic [31:0]                 r_end;
    logic [31:0]                 r_endEff;
    logic [31:0]                 r_arraySize;
    logic [32:0]                 r_chunk;
    logic [31:0]                 r_laneStart;
    logic [LANE_W-1:0]           r_lane;

    logic                        r_reqValid;
    MemoryPacketPayload          r_reqPayload;
    logic                        r_setup;
    logic                        r_busy;
    FIFOStateSignalsOutput       r_inSigOut;
    FIFOStateSignalsOutput       r_outSigOut;

    CSRIndexConfigurationPayload w_inDout;
    logic                        w_inFull;
    logic                        w_inEmpty;
    logic                        w_inProgFull;
    logic                        w_inBusy;
    logic                        w_inPop;

    MemoryPacketPayload          w_outDin;
    MemoryPacketPayload          w_outDout;
    logic                        w_outFull;
    logic                        w_outEmpty;
    logic                        w_outProgFull;
    logic                        w_outBusy;
    logic                        w_outPush;
    logic                        w_outPop;

    logic [31:0]                 w_span;
    logic [32:0]                 w_chunk;
    logic [33:0]                 w_laneSum;
    logic [31:0]                 w_lo;
    logic [31:0]                 w_hi;
    logic [31:0]                 w_laneNext;

    always_ff @(posedge ap_clk) begin
        r_reset <= areset;
    end

    always_ff @(posedge ap_clk) begin
        if (r_reset) begin
            r_inValid <= 1'b0;
            r_inRdEn  <= 1'b0;
            r_outRdEn <= 1'b0;
        end else begin
            r_inValid <= configure_in.valid;
            r_inRdEn  <= fifo_configure_in_signals_in.rd_en;
            r_outRdEn <= fifo_request_engine_out_signals_in.rd_en;
        end
    end

    always_ff @(posedge ap_clk) begin
        r_inData <= configure_in.payload;
    end

    // A new configuration is only taken once the previous one has fully drained
    assign w_inPop = ~w_inEmpty & r_inRdEn & (r_state == IDLE) & ~w_outProgFull;

    EngineMergeDataSetupFifo #(
        .WIDTH     (IN_W),
        .DEPTH     (FIFO_DEPTH),
        .PROG_FULL (PROG_FULL)
    ) u_inFifo (
        .clk        (ap_clk),
        .rst        (r_reset),
        .i_wrEn     (r_inValid),
        .i_din      (r_inData),
        .i_rdEn     (w_inPop),
        .o_dout     (w_inDout),
        .o_full     (w_inFull),
        .o_empty    (w_inEmpty),
        .o_progFull (w_inProgFull),
        .o_rstBusy  (w_inBusy)
    );

    // 33-bit rounding add keeps chunk exact even for a full 32-bit span
    assign w_span     = (r_end > r_start) ? (r_end - r_start) : 32'd0;
    assign w_chunk    = ({1'b0, w_span} + 33'(NUM_LANES - 1)) >> LANE_SHIFT;
    assign w_laneSum  = {2'b00, r_laneStart} + {1'b0, r_chunk};
    assign w_lo       = (r_laneStart < r_endEff) ? r_laneStart : r_endEff;
    assign w_hi       = (w_laneSum < {2'b00, r_endEff}) ? w_laneSum[31:0] : r_endEff;
    assign w_laneNext = (|w_laneSum[33:32]) ? 32'hFFFF_FFFF : w_laneSum[31:0];
    assign w_outPush  = (r_state == EMIT) & ~w_outProgFull;

    always_comb begin
        w_outDin                      = '0;
        w_outDin.meta                 = r_meta;
        w_outDin.meta.subclass.buffer = STRUCT_ENGINE_SETUP;
        w_outDin.data.field_0         = w_lo;
        w_outDin.data.field_1         = w_hi;
        w_outDin.data.field_2         = 32'(r_lane);
        w_outDin.data.field_3         = r_arraySize;
        w_outDin.source.id_cu         = 8'(ID_CU);
        w_outDin.source.id_bundle     = 8'(ID_BUNDLE);
        w_outDin.source.id_lane       = 8'(ID_LANE);
        w_outDin.source.id_engine     = 8'(ID_ENGINE);
    end

    always_ff @(posedge ap_clk) begin
        if (r_reset) begin
            r_state <= IDLE;
            r_lane  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_inPop) begin
                        r_meta      <= w_inDout.meta;
                        r_start     <= w_inDout.param.index_start;
                        r_end       <= w_inDout.param.index_end;
                        r_arraySize <= w_inDout.param.array_size;
                        r_endEff    <= (w_inDout.param.index_end > w_inDout.param.index_start)
                                       ? w_inDout.param.index_end : w_inDout.param.index_start;
                        r_state     <= CALC;
                    end
                end
                CALC: begin
                    r_chunk     <= w_chunk;
                    r_laneStart <= r_start;
                    r_lane      <= '0;
                    r_state     <= EMIT;
                end
                EMIT: begin
                    if (w_outPush) begin
                        r_laneStart <= w_laneNext;
                        if (r_lane == LANE_W'(NUM_LANES - 1)) begin
                            r_lane  <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_outPop = ~w_outEmpty & r_outRdEn;

    EngineMergeDataSetupFifo #(
        .WIDTH     (OUT_W),
        .DEPTH     (FIFO_DEPTH),
        .PROG_FULL (PROG_FULL)
    ) u_outFifo (
        .clk        (ap_clk),
        .rst        (r_reset),
        .i_wrEn     (w_outPush),
        .i_din      (w_outDin),
        .i_rdEn     (w_outPop),
        .o_dout     (w_outDout),
        .o_full     (w_outFull),
        .o_empty    (w_outEmpty),
        .o_progFull (w_outProgFull),
        .o_rstBusy  (w_outBusy)
    );

    always_ff @(posedge ap_clk) begin
        if (r_reset) begin
            r_reqValid  <= 1'b0;
            r_setup     <= 1'b1;
            r_busy      <= 1'b0;
            r_inSigOut  <= '{full: 1'b1, empty: 1'b1, prog_full: 1'b1};
            r_outSigOut <= '{full: 1'b1, empty: 1'b1, prog_full: 1'b1};
        end else begin
            r_reqValid  <= w_outPop;
            r_setup     <= w_inBusy | w_outBusy;
            r_busy      <= (r_state != IDLE);
            r_inSigOut  <= '{full: w_inFull, empty: w_inEmpty, prog_full: w_inProgFull};
            r_outSigOut <= '{full: w_outFull, empty: w_outEmpty, prog_full: w_outProgFull};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_outPop) begin
            r_reqPayload <= w_outDout;
        end
    end

    always_comb begin
        request_engine_out         = '0;
        request_engine_out.valid   = r_reqValid;
        request_engine_out.payload = r_reqPayload;
    end

    assign fifo_configure_in_signals_out       = r_inSigOut;
    assign fifo_request_engine_out_signals_out = r_outSigOut;
    assign fifo_setup_signal                   = r_setup;
    assign encoder_busy_out                    = r_busy;

endmodule

// File: tb/tb_engine_merge_data_setup_packet_encoder.sv
// Directed bench for the merge-data setup packet encoder with hand-computed
// sub-range tables, backpressure and mid-emit reset scenarios.

module tb_engine_merge_data_setup_packet_encoder;
    import engine_merge_data_setup_packet_encoder_pkg::*;

    logic                  ap_clk;
    logic                  areset;
    CSRIndexConfiguration  configure_in;
    FIFOStateSignalsInput  fifo_configure_in_signals_in;
    FIFOStateSignalsOutput fifo_configure_in_signals_out;
    MemoryPacket           request_engine_out;
    FIFOStateSignalsInput  fifo_request_engine_out_signals_in;
    FIFOStateSignalsOutput fifo_request_engine_out_signals_out;
    logic                  fifo_setup_signal;
    logic                  encoder_busy_out;

    int checks = 0;
    int errors = 0;
    int latency;
    int waitCyc;

    MemoryPacketPayload gotQ[$];
    MemoryPacketPayload expQ[$];
    MemoryPacketMeta    mA, mB, mC, mD, mE, mF, mG, mH, mI, mJ;

    engine_merge_data_setup_packet_encoder dut (
        .ap_clk                              (ap_clk),
        .areset                              (areset),
        .configure_in                        (configure_in),
        .fifo_configure_in_signals_in        (fifo_configure_in_signals_in),
        .fifo_configure_in_signals_out       (fifo_configure_in_signals_out),
        .request_engine_out                  (request_engine_out),
        .fifo_request_engine_out_signals_in  (fifo_request_engine_out_signals_in),
        .fifo_request_engine_out_signals_out (fifo_request_engine_out_signals_out),
        .fifo_setup_signal                   (fifo_setup_signal),
        .encoder_busy_out                    (encoder_busy_out)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Collect every emitted packet away from the active edge
    always @(negedge ap_clk) begin
        if (request_engine_out.valid === 1'b1) begin
            gotQ.push_back(request_engine_out.payload);
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic MemoryPacketMeta mkMeta(input logic [7:0] tag);
        MemoryPacketMeta m;
        m.route.id_cu        = tag;
        m.route.id_bundle    = 8'(tag + 8'd1);
        m.route.id_lane      = 8'(tag + 8'd2);
        m.route.id_engine    = tag ^ 8'hFF;
        m.subclass.cmd       = tag[3:0];
        m.subclass.buffer    = STRUCT_KERNEL_SETUP;
        return m;
    endfunction

    // Drives one configuration for one cycle; assumes the caller sits at a negedge
    task automatic applyStimulus(input MemoryPacketMeta m, input logic [31:0] s, input logic [31:0] e,
                                 input logic [31:0] arr);
        configure_in.valid                     = 1'b1;
        configure_in.payload.meta              = m;
        configure_in.payload.param.index_start = s;
        configure_in.payload.param.index_end   = e;
        configure_in.payload.param.array_size  = arr;
        @(negedge ap_clk);
        configure_in.valid = 1'b0;
    endtask

    task automatic expectPacket(input MemoryPacketMeta m, input logic [31:0] lo, input logic [31:0] hi,
                                input logic [31:0] k, input logic [31:0] arr);
        MemoryPacketPayload p;
        p                      = '0;
        p.meta                 = m;
        p.meta.subclass.buffer = STRUCT_ENGINE_SETUP;
        p.data.field_0         = lo;
        p.data.field_1         = hi;
        p.data.field_2         = k;
        p.data.field_3         = arr;
        expQ.push_back(p);
    endtask

    task automatic checkOutput(input string tag);
        int w;
        int n;
        w = 0;
        while (gotQ.size() < expQ.size() && w < 300) begin
            @(negedge ap_clk);
            w++;
        end
        repeat (4) @(negedge ap_clk);
        checkVal({tag, " count"}, 64'(gotQ.size()), 64'(expQ.size()));
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkVal($sformatf("%s[%0d] meta", tag, i), 64'(gotQ[i].meta), 64'(expQ[i].meta));
            checkVal($sformatf("%s[%0d] f0", tag, i), 64'(gotQ[i].data.field_0), 64'(expQ[i].data.field_0));
            checkVal($sformatf("%s[%0d] f1", tag, i), 64'(gotQ[i].data.field_1), 64'(expQ[i].data.field_1));
            checkVal($sformatf("%s[%0d] f2", tag, i), 64'(gotQ[i].data.field_2), 64'(expQ[i].data.field_2));
            checkVal($sformatf("%s[%0d] f3", tag, i), 64'(gotQ[i].data.field_3), 64'(expQ[i].data.field_3));
        end
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        mA = mkMeta(8'h10); mB = mkMeta(8'h21); mC = mkMeta(8'h32); mD = mkMeta(8'h43);
        mE = mkMeta(8'h54); mF = mkMeta(8'h65); mG = mkMeta(8'h76); mH = mkMeta(8'h87);
        mI = mkMeta(8'h98); mJ = mkMeta(8'hA9);

        areset                                   = 1'b1;
        configure_in                             = '0;
        fifo_configure_in_signals_in.rd_en       = 1'b1;
        fifo_request_engine_out_signals_in.rd_en = 1'b1;
        repeat (4) @(negedge ap_clk);
        checkVal("reset valid", 64'(request_engine_out.valid), 64'd0);
        checkVal("reset setup", 64'(fifo_setup_signal), 64'd1);
        checkVal("reset busy", 64'(encoder_busy_out), 64'd0);
        areset = 1'b0;
        waitCyc = 0;
        while (fifo_setup_signal !== 1'b0 && waitCyc < 20) begin
            @(negedge ap_clk);
            waitCyc++;
        end
        checkVal("setup done", 64'(fifo_setup_signal), 64'd0);
        checkVal("idle in empty", 64'(fifo_configure_in_signals_out.empty), 64'd1);
        checkVal("idle out prog_full", 64'(fifo_request_engine_out_signals_out.prog_full), 64'd0);

        // Even split, also measuring input-to-first-packet latency
        configure_in.valid                     = 1'b1;
        configure_in.payload.meta              = mA;
        configure_in.payload.param.index_start = 32'd0;
        configure_in.payload.param.index_end   = 32'd100;
        configure_in.payload.param.array_size  = 32'd100;
        latency = 0;
        while (latency < 20) begin
            @(negedge ap_clk);
            latency++;
            configure_in.valid = 1'b0;
            if (request_engine_out.valid === 1'b1) break;
        end
        checkVal("latency", 64'(latency), 64'd6);
        expectPacket(mA, 32'd0,  32'd25,  32'd0, 32'd100);
        expectPacket(mA, 32'd25, 32'd50,  32'd1, 32'd100);
        expectPacket(mA, 32'd50, 32'd75,  32'd2, 32'd100);
        expectPacket(mA, 32'd75, 32'd100, 32'd3, 32'd100);
        checkOutput("even");

        applyStimulus(mB, 32'd10, 32'd13, 32'd3);
        expectPacket(mB, 32'd10, 32'd11, 32'd0, 32'd3);
        expectPacket(mB, 32'd11, 32'd12, 32'd1, 32'd3);
        expectPacket(mB, 32'd12, 32'd13, 32'd2, 32'd3);
        expectPacket(mB, 32'd13, 32'd13, 32'd3, 32'd3);
        checkOutput("short");

        applyStimulus(mC, 32'd5, 32'd5, 32'd1);
        applyStimulus(mD, 32'd9, 32'd3, 32'd2);
        for (int k = 0; k < 4; k++) expectPacket(mC, 32'd5, 32'd5, 32'(k), 32'd1);
        for (int k = 0; k < 4; k++) expectPacket(mD, 32'd9, 32'd9, 32'(k), 32'd2);
        checkOutput("empty_inverted");

        applyStimulus(mE, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd77);
        applyStimulus(mF, 32'd200, 32'd208, 32'd8);
        expectPacket(mE, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'd0, 32'd77);
        expectPacket(mE, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'd1, 32'd77);
        expectPacket(mE, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd2, 32'd77);
        expectPacket(mE, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd3, 32'd77);
        expectPacket(mF, 32'd200, 32'd202, 32'd0, 32'd8);
        expectPacket(mF, 32'd202, 32'd204, 32'd1, 32'd8);
        expectPacket(mF, 32'd204, 32'd206, 32'd2, 32'd8);
        expectPacket(mF, 32'd206, 32'd208, 32'd3, 32'd8);
        checkOutput("saturate");

        // Backpressure: eight packets fill to prog_full, third config waits upstream
        fifo_request_engine_out_signals_in.rd_en = 1'b0;
        @(negedge ap_clk);
        applyStimulus(mG, 32'd1000, 32'd1012, 32'd12);
        applyStimulus(mH, 32'd0, 32'd7, 32'd7);
        applyStimulus(mI, 32'd50, 32'd40, 32'd9);
        repeat (40) @(negedge ap_clk);
        checkVal("bp no output", 64'(gotQ.size()), 64'd0);
        checkVal("bp out prog_full", 64'(fifo_request_engine_out_signals_out.prog_full), 64'd1);
        checkVal("bp in not empty", 64'(fifo_configure_in_signals_out.empty), 64'd0);
        checkVal("bp encoder idle", 64'(encoder_busy_out), 64'd0);
        fifo_request_engine_out_signals_in.rd_en = 1'b1;
        expectPacket(mG, 32'd1000, 32'd1003, 32'd0, 32'd12);
        expectPacket(mG, 32'd1003, 32'd1006, 32'd1, 32'd12);
        expectPacket(mG, 32'd1006, 32'd1009, 32'd2, 32'd12);
        expectPacket(mG, 32'd1009, 32'd1012, 32'd3, 32'd12);
        expectPacket(mH, 32'd0, 32'd2, 32'd0, 32'd7);
        expectPacket(mH, 32'd2, 32'd4, 32'd1, 32'd7);
        expectPacket(mH, 32'd4, 32'd6, 32'd2, 32'd7);
        expectPacket(mH, 32'd6, 32'd7, 32'd3, 32'd7);
        for (int k = 0; k < 4; k++) expectPacket(mI, 32'd50, 32'd50, 32'(k), 32'd9);
        checkOutput("backpressure");

        // Reset raised as lane 2 is being emitted; only lanes 0 and 1 escape
        configure_in.valid                     = 1'b1;
        configure_in.payload.meta              = mJ;
        configure_in.payload.param.index_start = 32'd0;
        configure_in.payload.param.index_end   = 32'd40;
        configure_in.payload.param.array_size  = 32'd40;
        latency = 0;
        while (latency < 20) begin
            @(negedge ap_clk);
            latency++;
            configure_in.valid = 1'b0;
            if (request_engine_out.valid === 1'b1) break;
        end
        checkVal("rst first valid", 64'(latency), 64'd6);
        areset = 1'b1;
        repeat (3) @(negedge ap_clk);
        checkVal("rst setup high", 64'(fifo_setup_signal), 64'd1);
        checkVal("rst busy low", 64'(encoder_busy_out), 64'd0);
        checkVal("rst valid low", 64'(request_engine_out.valid), 64'd0);
        areset = 1'b0;
        waitCyc = 0;
        while (fifo_setup_signal !== 1'b0 && waitCyc < 20) begin
            @(negedge ap_clk);
            waitCyc++;
        end
        checkVal("rst setup done", 64'(fifo_setup_signal), 64'd0);
        repeat (10) @(negedge ap_clk);
        checkVal("rst escaped count", 64'(gotQ.size()), 64'd2);
        if (gotQ.size() >= 2) begin
            checkVal("rst escaped lane0", 64'(gotQ[0].data.field_2), 64'd0);
            checkVal("rst escaped lane1", 64'(gotQ[1].data.field_2), 64'd1);
            checkVal("rst escaped f1", 64'(gotQ[1].data.field_1), 64'd20);
        end
        gotQ.delete();

        applyStimulus(mA, 32'd300, 32'd304, 32'd4);
        expectPacket(mA, 32'd300, 32'd301, 32'd0, 32'd4);
        expectPacket(mA, 32'd301, 32'd302, 32'd1, 32'd4);
        expectPacket(mA, 32'd302, 32'd303, 32'd2, 32'd4);
        expectPacket(mA, 32'd303, 32'd304, 32'd3, 32'd4);
        checkOutput("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/engine_merge_data_setup_packet_encoder.md
Name: engine_merge_data_setup_packet_encoder

Overview:
- Transmit-side counterpart of the merge-data configure path.
- Pops CSRIndexConfiguration records from an input FIFO and splits each index range [index_start, index_end) into NUM_LANES contiguous sub-ranges.
- Encodes each sub-range as one engine-setup MemoryPacket (subclass.buffer = STRUCT_ENGINE_SETUP) on the request side of the lane.
- The downstream merge-data configure engines decode these packets back into per-lane index configurations.

Parameters:
- ID_CU, 0: compute-unit id.
- ID_BUNDLE, 0: bundle id.
- ID_LANE, 0: lane id.
- ID_ENGINE, 0: engine id.
- NUM_LANES, 4: number of sub-ranges per configuration. Must be a power of two, 1..16.
- FIFO_DEPTH, 16: depth of the input FIFO and of the output FIFO. Both FIFOs have prog_full threshold FIFO_DEPTH/2.

Ports:
- ap_clk  in  1  clock; single clock domain.
- areset  in  1  reset; synchronous, active-high.
- configure_in  in  CSRIndexConfiguration  valid + payload (meta, param.index_start, param.index_end, param.array_size).
- fifo_configure_in_signals_in  in  FIFOStateSignalsInput  rd_en enables popping the input FIFO.
- fifo_configure_in_signals_out  out  FIFOStateSignalsOutput  input FIFO state; upstream must stop pushing while prog_full=1.
- request_engine_out  out  MemoryPacket  encoded setup packet.
- fifo_request_engine_out_signals_in  in  FIFOStateSignalsInput  downstream rd_en.
- fifo_request_engine_out_signals_out  out  FIFOStateSignalsOutput  output FIFO state.
- fifo_setup_signal  out  1  1 while either FIFO is in reset (wr_rst_busy | rd_rst_busy).
- encoder_busy_out  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset and registering:
  - areset is registered once internally; that registered copy resets all state.
  - Inputs (valid, rd_en) are registered one cycle. Outputs are registered one cycle.
  - Reset values: request_engine_out.valid=0, fifo_setup_signal=1, encoder_busy_out=0, FSM=IDLE, lane counter=0.
  - Payload registers are not reset.
- Input FIFO:
  - Push when configure_in.valid is 1 (registered copy).
  - Pop when !empty & registered rd_en & FSM==IDLE & !output prog_full.
- FSM states:
  - IDLE: on the input FIFO's dout valid, capture meta, start, end and array_size, then go to CALC.
  - CALC (1 cycle):
    - span = (end > start) ? end - start : 0, 32-bit unsigned.
    - chunk = (span + NUM_LANES - 1) >> log2(NUM_LANES), computed in 33 bits with no overflow.
    - lane_start = start, k = 0. Go to EMIT.
  - EMIT:
    - Each cycle, if output prog_full=0, push one packet for lane k. If prog_full=1, stall and hold k and lane_start.
    - After pushing lane k = NUM_LANES-1, go to IDLE.
- Packet encoding for lane k:
  - lo = min(lane_start, end_eff) and hi = min(lane_start + chunk, end_eff), where end_eff = max(start, end).
  - field_0 = lo, field_1 = hi, field_2 = k, field_3 = array_size.
  - meta = captured meta, except meta.subclass.buffer is forced to STRUCT_ENGINE_SETUP.
  - After each push, lane_start += chunk, saturating at 32'hFFFFFFFF.
- Range properties:
  - Exactly NUM_LANES packets are emitted per configuration, always.
  - Empty or inverted ranges produce NUM_LANES packets with field_0 = field_1 = start.
  - Sub-ranges are contiguous and non-overlapping; their union is [start, end_eff).
- Ordering: configurations are processed strictly in FIFO order. Packets go out in lane order 0..NUM_LANES-1 with no interleaving between configurations.
- Output FIFO:
  - Push equals the EMIT push.
  - Pop when !empty & registered downstream rd_en.
  - request_engine_out.valid is the FIFO valid, delayed one register.
- Latency: input push to first output packet valid is 6 cycles with no backpressure (input reg, FIFO, IDLE capture, CALC, EMIT/FIFO, output reg).
- Simultaneous events: an input push and pop in the same cycle is legal. An output pop during an EMIT push is legal.
- Reset mid-EMIT: all in-flight state is discarded. Both FIFOs are flushed. No partial packet appears after reset. fifo_setup_signal=1 until both FIFOs report reset done.

Test Plan:
- Even split: NUM_LANES=4, start=0, end=100, array_size=100 -> (field_0, field_1, field_2) = (0,25,0), (25,50,1), (50,75,2), (75,100,3); field_3=100 on all; subclass.buffer=STRUCT_ENGINE_SETUP.
- Uneven/short range: start=10, end=13 -> chunk=1 -> (10,11), (11,12), (12,13), (13,13).
- Empty/inverted range: start=5, end=5 and start=9, end=3 -> four packets each, all (5,5) and all (9,9) respectively.
- Backpressure: downstream rd_en=0 and 3 configs pushed -> output prog_full at 8 stalls EMIT. The input FIFO holds the remainder with no loss. Release rd_en -> 12 packets emitted in order.
- Back-to-back configs plus saturation: start=32'hFFFFFFF0, end=32'hFFFFFFFF -> chunk=4; last packet = (32'hFFFFFFFC, 32'hFFFFFFFF); the following config is emitted unchanged.
- Reset asserted during EMIT at lane 2 -> no further packets. fifo_setup_signal=1 during FIFO reset. encoder_busy_out=0. A new config after reset is emitted correctly from lane 0.
